// File: rtl/ritc_align_sequencer_pkg.sv
// Shared definitions for the RITC IDELAY-eye / bitslip alignment sequencer:
// user-port register map, data-word field positions and the sequencer state encoding.
`timescale 1ns/1ps
package ritc_align_sequencer_pkg;

    localparam logic [3:0] ADR_RESET      = 4'h0;
    localparam logic [3:0] ADR_BITSLIP    = 4'h1;
    localparam logic [3:0] ADR_IDELAY_VAL = 4'h2;
    localparam logic [3:0] ADR_IDELAY_CTL = 4'h3;
    localparam logic [3:0] SAMPLE_ADR     = 4'h4;

    localparam int TAP_LSB       = 0;
    localparam int BIT_LSB       = 8;
    localparam int CHAN_LSB      = 16;
    localparam int SLIP_CHAN_LSB = 0;
    localparam int SLIP_FLAG_BIT = 8;

    localparam logic [2:0] MAX_CHAN = 3'd5;
    localparam logic [3:0] MAX_BIT  = 4'd11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SET_TAP,
        ST_LOAD,
        ST_SETTLE,
        ST_RD,
        ST_WAIT,
        ST_EVAL,
        ST_NEXT_TAP,
        ST_SLIP,
        ST_DONE,
        ST_FAIL
    } state_t;

    function automatic logic [31:0] idelay_word(input logic [4:0] tap,
                                                input logic [3:0] bit_sel,
                                                input logic [2:0] chan);
        logic [31:0] w;
        w = '0;
        w[TAP_LSB +: 5]  = tap;
        w[BIT_LSB +: 4]  = bit_sel;
        w[CHAN_LSB +: 3] = chan;
        return w;
    endfunction

    function automatic logic [31:0] slip_word(input logic [2:0] chan);
        logic [31:0] w;
        w = '0;
        w[SLIP_CHAN_LSB +: 3] = chan;
        w[SLIP_FLAG_BIT]      = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/ritc_align_sequencer_eye_tracker.sv
// Good-tap run tracker: follows the current run of good taps and keeps the longest one,
// with ties resolved in favour of the earliest run.
`timescale 1ns/1ps
module ritc_eye_tracker #(
    parameter int TAP_W = 5,
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic             good,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] run_start,
    output logic [LEN_W-1:0] run_len,
    output logic [TAP_W-1:0] best_start,
    output logic [LEN_W-1:0] best_len
);

    logic [TAP_W-1:0] run_start_reg, run_start_next;
    logic [LEN_W-1:0] run_len_reg, run_len_next;
    logic [TAP_W-1:0] best_start_reg, best_start_next;
    logic [LEN_W-1:0] best_len_reg, best_len_next;

    always_comb begin
        run_start_next  = run_start_reg;
        run_len_next    = run_len_reg;
        best_start_next = best_start_reg;
        best_len_next   = best_len_reg;
        if (clear) begin
            run_start_next  = '0;
            run_len_next    = '0;
            best_start_next = '0;
            best_len_next   = '0;
        end else if (valid) begin
            if (good) begin
                run_start_next = (run_len_reg == '0) ? tap : run_start_reg;
                run_len_next   = run_len_reg + 1'b1;
                // strictly longer only, so an equal later run never displaces the first
                if (run_len_next > best_len_reg) begin
                    best_start_next = run_start_next;
                    best_len_next   = run_len_next;
                end
            end else begin
                run_len_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_start_reg  <= '0;
            run_len_reg    <= '0;
            best_start_reg <= '0;
            best_len_reg   <= '0;
        end else begin
            run_start_reg  <= run_start_next;
            run_len_reg    <= run_len_next;
            best_start_reg <= best_start_next;
            best_len_reg   <= best_len_next;
        end
    end

    assign run_start  = run_start_reg;
    assign run_len    = run_len_reg;
    assign best_start = best_start_reg;
    assign best_len   = best_len_reg;

endmodule

// File: rtl/ritc_align_sequencer.sv
// Autonomous IDELAY eye scan + bitslip aligner for one RITC data bit; masters the
// RITC user register port while busy_o is high.
`timescale 1ns/1ps
module ritc_align_sequencer
    import ritc_align_sequencer_pkg::*;
#(
    parameter int         NTAPS     = 32,
    parameter int         NREADS    = 4,
    parameter int         SETTLE    = 16,
    parameter int         RD_LAT    = 2,
    parameter int         MIN_EYE   = 4,
    parameter int         MAX_SLIPS = 8,
    parameter logic [3:0] TRAIN_PAT = 4'hA
) (
    input  logic        user_clk_i,
    input  logic        user_rst_n_i,
    input  logic        start_i,
    input  logic [2:0]  chan_i,
    input  logic [3:0]  bit_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [4:0]  tap_o,
    output logic [4:0]  eye_start_o,
    output logic [5:0]  eye_len_o,
    output logic [3:0]  slips_o,
    output logic        m_sel_o,
    output logic [3:0]  m_addr_o,
    output logic        m_wr_o,
    output logic        m_rd_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i
);

    localparam logic [4:0] LAST_TAP   = 5'(NTAPS - 1);
    localparam logic [7:0] SETTLE_M1  = 8'(SETTLE - 1);
    localparam logic [7:0] WAIT_M1    = 8'(RD_LAT - 2);
    localparam logic [7:0] LAST_READ  = 8'(NREADS - 1);
    localparam logic [5:0] MIN_EYE_W  = 6'(MIN_EYE);
    localparam logic [3:0] MAX_SLIP_W = 4'(MAX_SLIPS);

    state_t      state_reg, state_next;
    logic [4:0]  tap_reg, tap_next;
    logic [2:0]  chan_reg, chan_next;
    logic [3:0]  bit_reg, bit_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [7:0]  rd_cnt_reg, rd_cnt_next;
    logic [3:0]  first_nib_reg, first_nib_next;
    logic        agree_reg, agree_next;
    logic [3:0]  slips_reg, slips_next;
    logic        check_reg, check_next;

    logic        trk_clear, trk_valid, trk_good;
    logic [4:0]  best_start;
    logic [5:0]  best_len;
    logic [4:0]  unused_run_start;
    logic [5:0]  unused_run_len;
    logic        unused_dat;

    logic [3:0]  nib;
    logic        agree_now;

    assign nib        = m_dat_i[3:0];
    assign unused_dat = ^m_dat_i[31:4];
    assign agree_now  = (rd_cnt_reg == 8'd0) || (agree_reg && (nib == first_nib_reg));

    ritc_eye_tracker #(
        .TAP_W (5),
        .LEN_W (6)
    ) u_eye_tracker (
        .clk        (user_clk_i),
        .rst_n      (user_rst_n_i),
        .clear      (trk_clear),
        .valid      (trk_valid),
        .good       (trk_good),
        .tap        (tap_reg),
        .run_start  (unused_run_start),
        .run_len    (unused_run_len),
        .best_start (best_start),
        .best_len   (best_len)
    );

    always_comb begin
        state_next     = state_reg;
        tap_next       = tap_reg;
        chan_next      = chan_reg;
        bit_next       = bit_reg;
        cnt_next       = cnt_reg;
        rd_cnt_next    = rd_cnt_reg;
        first_nib_next = first_nib_reg;
        agree_next     = agree_reg;
        slips_next     = slips_reg;
        check_next     = check_reg;
        trk_clear      = 1'b0;
        trk_valid      = 1'b0;
        trk_good       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    chan_next  = chan_i;
                    bit_next   = bit_i;
                    tap_next   = '0;
                    slips_next = '0;
                    check_next = 1'b0;
                    trk_clear  = 1'b1;
                    state_next = (chan_i > MAX_CHAN || bit_i > MAX_BIT) ? ST_FAIL : ST_SET_TAP;
                end
            end
            ST_SET_TAP: state_next = ST_LOAD;
            ST_LOAD: begin
                cnt_next    = SETTLE_M1;
                rd_cnt_next = '0;
                state_next  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_reg == 8'd0) state_next = ST_RD;
                else                 cnt_next   = cnt_reg - 8'd1;
            end
            ST_RD: begin
                cnt_next   = WAIT_M1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_reg == 8'd0) state_next = ST_EVAL;
                else                 cnt_next   = cnt_reg - 8'd1;
            end
            ST_EVAL: begin
                if (check_reg) begin
                    // alignment check after centering or after a slip
                    if (nib == TRAIN_PAT)             state_next = ST_DONE;
                    else if (slips_reg == MAX_SLIP_W) state_next = ST_FAIL;
                    else                              state_next = ST_SLIP;
                end else begin
                    first_nib_next = (rd_cnt_reg == 8'd0) ? nib : first_nib_reg;
                    agree_next     = agree_now;
                    if (rd_cnt_reg == LAST_READ) begin
                        trk_valid  = 1'b1;
                        trk_good   = agree_now && (nib != 4'h0) && (nib != 4'hF);
                        state_next = ST_NEXT_TAP;
                    end else begin
                        rd_cnt_next = rd_cnt_reg + 8'd1;
                        state_next  = ST_RD;
                    end
                end
            end
            ST_NEXT_TAP: begin
                if (tap_reg == LAST_TAP) begin
                    if (best_len < MIN_EYE_W) begin
                        state_next = ST_FAIL;
                    end else begin
                        tap_next   = best_start + best_len[5:1];
                        check_next = 1'b1;
                        state_next = ST_SET_TAP;
                    end
                end else begin
                    tap_next   = tap_reg + 5'd1;
                    state_next = ST_SET_TAP;
                end
            end
            ST_SLIP: begin
                slips_next = slips_reg + 4'd1;
                cnt_next   = SETTLE_M1;
                state_next = ST_SETTLE;
            end
            ST_DONE: state_next = ST_IDLE;
            ST_FAIL: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk_i) begin
        if (!user_rst_n_i) begin
            state_reg     <= ST_IDLE;
            tap_reg       <= '0;
            chan_reg      <= '0;
            bit_reg       <= '0;
            cnt_reg       <= '0;
            rd_cnt_reg    <= '0;
            first_nib_reg <= '0;
            agree_reg     <= 1'b0;
            slips_reg     <= '0;
            check_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tap_reg       <= tap_next;
            chan_reg      <= chan_next;
            bit_reg       <= bit_next;
            cnt_reg       <= cnt_next;
            rd_cnt_reg    <= rd_cnt_next;
            first_nib_reg <= first_nib_next;
            agree_reg     <= agree_next;
            slips_reg     <= slips_next;
            check_reg     <= check_next;
        end
    end

    // Bus strobes come straight from the state register: each access state lasts one cycle.
    always_comb begin
        m_sel_o  = 1'b0;
        m_wr_o   = 1'b0;
        m_rd_o   = 1'b0;
        m_addr_o = '0;
        m_dat_o  = '0;
        case (state_reg)
            ST_SET_TAP: begin
                m_sel_o  = 1'b1;
                m_wr_o   = 1'b1;
                m_addr_o = ADR_IDELAY_VAL;
                m_dat_o  = idelay_word(tap_reg, bit_reg, chan_reg);
            end
            ST_LOAD: begin
                m_sel_o  = 1'b1;
                m_wr_o   = 1'b1;
                m_addr_o = ADR_IDELAY_CTL;
                m_dat_o  = 32'd1;
            end
            ST_RD: begin
                m_sel_o  = 1'b1;
                m_rd_o   = 1'b1;
                m_addr_o = SAMPLE_ADR;
            end
            ST_SLIP: begin
                m_sel_o  = 1'b1;
                m_wr_o   = 1'b1;
                m_addr_o = ADR_BITSLIP;
                m_dat_o  = slip_word(chan_reg);
            end
            default: ;
        endcase
    end

    assign busy_o      = (state_reg != ST_IDLE) && (state_reg != ST_DONE) && (state_reg != ST_FAIL);
    assign done_o      = (state_reg == ST_DONE);
    assign fail_o      = (state_reg == ST_FAIL);
    assign tap_o       = tap_reg;
    assign eye_start_o = best_start;
    assign eye_len_o   = best_len;
    assign slips_o     = slips_reg;

endmodule

// File: tb/tb_ritc_align_sequencer.sv
// Self-checking bench: an emulated RITC user port with a per-tap eye model drives the
// sequencer; expected results come from a run-length reference over the same eye map.
`timescale 1ns/1ps
module tb_ritc_align_sequencer;

    localparam int NTAPS     = 32;
    localparam int NREADS    = 4;
    localparam int RD_LAT    = 2;
    localparam int MIN_EYE   = 4;
    localparam int MAX_SLIPS = 8;

    logic        clk = 1'b0;
    logic        user_rst_n_i;
    logic        start_i;
    logic [2:0]  chan_i;
    logic [3:0]  bit_i;
    logic        busy_o, done_o, fail_o;
    logic [4:0]  tap_o, eye_start_o;
    logic [5:0]  eye_len_o;
    logic [3:0]  slips_o;
    logic        m_sel_o, m_wr_o, m_rd_o;
    logic [3:0]  m_addr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i = 32'h0;

    always #5 clk = ~clk;

    ritc_align_sequencer dut (
        .user_clk_i   (clk),
        .user_rst_n_i (user_rst_n_i),
        .start_i      (start_i),
        .chan_i       (chan_i),
        .bit_i        (bit_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fail_o       (fail_o),
        .tap_o        (tap_o),
        .eye_start_o  (eye_start_o),
        .eye_len_o    (eye_len_o),
        .slips_o      (slips_o),
        .m_sel_o      (m_sel_o),
        .m_addr_o     (m_addr_o),
        .m_wr_o       (m_wr_o),
        .m_rd_o       (m_rd_o),
        .m_dat_o      (m_dat_o),
        .m_dat_i      (m_dat_i)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Eye map and slip requirement of the emulated link (written by the stimulus process only)
    logic       good_tap [NTAPS];
    int         bad_mode [NTAPS];
    int         slips_need = 0;
    int         slips_base = 0;

    // Bus observations (written by the port emulator only)
    int          strobe_cnt = 0, wr1_cnt = 0, wr2_cnt = 0, wr3_cnt = 0, rd_cnt = 0;
    logic [31:0] last_wr1 = 0, last_wr2 = 0;
    logic [4:0]  cur_tap = 0;
    int          rd_seq = 0, rd_pend = 0;
    logic [3:0]  rd_nib = 0;

    function automatic logic [3:0] sample_nibble();
        logic [31:0] seq;
        seq = 32'(rd_seq);
        if (good_tap[cur_tap])
            return ((wr1_cnt - slips_base) >= slips_need) ? 4'hA : 4'h5;
        case (bad_mode[cur_tap])
            0:       return 4'h0;
            1:       return 4'hF;
            default: return seq[3:0];
        endcase
    endfunction

    // RITC user-port emulation: latches writes, answers sample reads RD_LAT cycles later
    always @(negedge clk) begin
        logic [31:0] junk;
        junk = $urandom;
        if (rd_pend != 0) begin
            rd_pend = rd_pend - 1;
            m_dat_i = (rd_pend == 0) ? {junk[31:4], rd_nib} : junk;
        end else begin
            m_dat_i = junk;
        end
        if (m_sel_o) begin
            strobe_cnt++;
            if (m_wr_o) begin
                case (m_addr_o)
                    4'h1: begin wr1_cnt++; last_wr1 = m_dat_o; end
                    4'h2: begin wr2_cnt++; last_wr2 = m_dat_o; cur_tap = m_dat_o[4:0]; end
                    4'h3: wr3_cnt++;
                    default: ;
                endcase
            end
            if (m_rd_o && m_addr_o == 4'h4) begin
                rd_cnt++;
                rd_seq++;
                rd_nib  = sample_nibble();
                rd_pend = RD_LAT;
            end
        end
    end

    // Longest good run, earliest on ties: scan every run start and measure it.
    task automatic ref_eye(output int bs, output int bl);
        bs = 0;
        bl = 0;
        for (int s = 0; s < NTAPS; s++) begin
            if (good_tap[s] && (s == 0 || !good_tap[s-1])) begin
                int len;
                len = 0;
                while (s + len < NTAPS && good_tap[s+len]) len++;
                if (len > bl) begin bl = len; bs = s; end
            end
        end
    endtask

    task automatic set_eye(input int lo, input int hi);
        for (int t = lo; t <= hi && t < NTAPS; t++) good_tap[t] = 1'b1;
    endtask

    task automatic clear_eye();
        for (int t = 0; t < NTAPS; t++) begin
            good_tap[t] = 1'b0;
            bad_mode[t] = $urandom_range(0, 2);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return {2'b0, busy_o, done_o, fail_o, tap_o, eye_start_o, eye_len_o, slips_o,
                m_sel_o, m_wr_o, m_rd_o, m_addr_o};
    endfunction

    task automatic run_case(input int id, input logic [2:0] ch, input logic [3:0] bt,
                            input int need, input bit poke_busy);
        int bs, bl, center, exp_slips, exp_last_tap, cyc;
        int b1, b2, b3, brd;
        bit eye_ok, exp_done, fin;
        logic [4:0] lt;
        ref_eye(bs, bl);
        eye_ok       = (bl >= MIN_EYE);
        center       = bs + bl / 2;
        exp_slips    = eye_ok ? ((need > MAX_SLIPS) ? MAX_SLIPS : need) : 0;
        exp_done     = eye_ok && (need <= MAX_SLIPS);
        exp_last_tap = eye_ok ? center : NTAPS - 1;
        lt           = 5'(exp_last_tap);
        b1 = wr1_cnt; b2 = wr2_cnt; b3 = wr3_cnt; brd = rd_cnt;
        slips_need = need;
        slips_base = wr1_cnt;

        chan_i  = ch;
        bit_i   = bt;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check_value("busy_after_start", 32'(busy_o), 1);

        fin = 1'b0;
        cyc = 0;
        while (!fin && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (done_o || fail_o) begin
                fin = 1'b1;
            end else if (poke_busy && cyc == 100) begin
                chan_i  = 3'd6;
                start_i = 1'b1;
            end else if (poke_busy && cyc == 101) begin
                chan_i  = ch;
                start_i = 1'b0;
            end
        end
        check_value("finished_in_budget", 32'(fin), 1);
        check_value("done", 32'(done_o), 32'(exp_done));
        check_value("fail", 32'(fail_o), 32'(!exp_done));
        check_value("busy_at_pulse", 32'(busy_o), 0);
        check_value("tap", 32'(tap_o), 32'(exp_last_tap));
        check_value("eye_start", 32'(eye_start_o), 32'(bs));
        check_value("eye_len", 32'(eye_len_o), 32'(bl));
        check_value("slips", 32'(slips_o), 32'(exp_slips));
        check_value("slip_writes", 32'(wr1_cnt - b1), 32'(exp_slips));
        check_value("idelay_writes", 32'(wr2_cnt - b2), 32'(NTAPS + (eye_ok ? 1 : 0)));
        check_value("load_writes", 32'(wr3_cnt - b3), 32'(NTAPS + (eye_ok ? 1 : 0)));
        check_value("sample_reads", 32'(rd_cnt - brd),
                    32'(NTAPS * NREADS + (eye_ok ? exp_slips + 1 : 0)));
        check_value("last_idelay_dat", last_wr2, {13'h0, ch, 4'h0, bt, 3'h0, lt});
        if (exp_slips > 0) check_value("slip_dat", last_wr1, {23'h0, 1'b1, 5'h0, ch});
        $display("case %0d: chan=%0d bit=%0d need=%0d -> done=%0d fail=%0d tap=%0d eye=%0d+%0d slips=%0d",
                 id, ch, bt, need, done_o, fail_o, tap_o, eye_start_o, eye_len_o, slips_o);
        @(negedge clk);
        check_value("pulse_one_cycle", 32'(done_o | fail_o), 0);
        check_value("results_hold", 32'(eye_len_o), 32'(bl));
    endtask

    task automatic bad_start(input logic [2:0] ch, input logic [3:0] bt);
        int s;
        s       = strobe_cnt;
        chan_i  = ch;
        bit_i   = bt;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check_value("bad_sel_fail", 32'(fail_o), 1);
        check_value("bad_sel_done", 32'(done_o), 0);
        check_value("bad_sel_busy", 32'(busy_o), 0);
        repeat (5) @(negedge clk);
        check_value("bad_sel_no_bus", 32'(strobe_cnt - s), 0);
        $display("bad start: chan=%0d bit=%0d -> fail pulse", ch, bt);
    endtask

    initial begin
        int s, cyc;
        bit hit;
        user_rst_n_i = 1'b0;
        start_i      = 1'b0;
        chan_i       = 3'd0;
        bit_i        = 4'd0;
        clear_eye();
        repeat (3) @(negedge clk);
        check_value("reset_outputs", outs_vec(), 0);
        check_value("reset_dat", m_dat_o, 0);
        user_rst_n_i = 1'b1;
        @(negedge clk);

        // Centered eye 10..17, aligned with no slips
        clear_eye(); set_eye(10, 17);
        run_case(1, 3'd2, 4'd5, 0, 1'b0);
        check_value("case1_word", last_wr2, 32'h0002_050E);
        check_value("case1_tap", 32'(tap_o), 14);

        // Two equal runs: the earlier one wins
        clear_eye(); set_eye(3, 7); set_eye(20, 24);
        run_case(2, 3'd0, 4'd0, 0, 1'b0);

        // Eye too narrow at the top of the tap range
        clear_eye(); set_eye(29, 31);
        run_case(3, 3'd1, 4'd3, 2, 1'b0);

        // Three slips to lock; start pulses while busy are ignored
        clear_eye(); set_eye(8, 20);
        run_case(4, 3'd4, 4'd11, 3, 1'b1);

        // Pattern never appears within the slip budget, and exactly at the budget
        clear_eye(); set_eye(0, 6);
        run_case(5, 3'd5, 4'd7, 9, 1'b0);
        clear_eye(); set_eye(12, 30);
        run_case(6, 3'd3, 4'd2, MAX_SLIPS, 1'b0);

        bad_start(3'd6, 4'd0);
        bad_start(3'd2, 4'd12);

        // Reset in the middle of the scan
        clear_eye(); set_eye(5, 25);
        slips_need = 0;
        slips_base = wr1_cnt;
        chan_i  = 3'd1;
        bit_i   = 4'd9;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (last_wr2[4:0] == 5'd12 && busy_o) hit = 1'b1;
        end
        check_value("reached_tap12", 32'(hit), 1);
        repeat (3) @(negedge clk);
        user_rst_n_i = 1'b0;
        @(negedge clk);
        check_value("midscan_reset_outputs", outs_vec(), 0);
        check_value("midscan_reset_dat", m_dat_o, 0);
        @(negedge clk);
        user_rst_n_i = 1'b1;
        s = strobe_cnt;
        repeat (40) @(negedge clk);
        check_value("no_bus_after_reset", 32'(strobe_cnt - s), 0);
        $display("mid-scan reset at tap 12 -> outputs cleared, bus quiet");
        run_case(7, 3'd1, 4'd9, 1, 1'b0);

        // Randomized eyes, slip requirements and selections
        for (int k = 0; k < 6; k++) begin
            int nruns;
            clear_eye();
            nruns = $urandom_range(1, 3);
            for (int r = 0; r < nruns; r++) begin
                int st;
                st = $urandom_range(0, NTAPS - 1);
                set_eye(st, st + $urandom_range(0, 9));
            end
            run_case(10 + k, 3'($urandom_range(0, 5)), 4'($urandom_range(0, 11)),
                     $urandom_range(0, 10), (k == 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
